// File: rtl/bkm_iter_ctrl_if.sv
// Handshake and datapath bundle between the FPU front end, the BKM iteration
// controller and the single reused bkm_data_step instance.
// The slave modport is the controller's view. The master modport is the
// environment's view: the front end, the result consumer and the step datapath.
interface bkm_iter_ctrl_if #(
  parameter int W  = 64,
  parameter int NW = 6
);
  // cancel of the operation in flight
  logic          abort;

  // operand request channel
  logic          in_valid;
  logic          in_ready;
  logic          in_mode;
  logic [1:0]    in_format;
  logic [W-1:0]  in_X0;
  logic [W-1:0]  in_Y0;

  // step datapath channel
  logic          step_en;
  logic [NW-1:0] step_n;
  logic          step_mode;
  logic [1:0]    step_format;
  logic [W-1:0]  step_X_n;
  logic [W-1:0]  step_Y_n;
  logic [W-1:0]  step_X_np1;
  logic [W-1:0]  step_Y_np1;

  // result channel
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_X;
  logic [W-1:0]  out_Y;

  // status
  logic          busy;

  modport slave (
    input  abort, in_valid, in_mode, in_format, in_X0, in_Y0,
    input  step_X_np1, step_Y_np1, out_ready,
    output in_ready, step_en, step_n, step_mode, step_format,
    output step_X_n, step_Y_n, out_valid, out_X, out_Y, busy
  );

  modport master (
    output abort, in_valid, in_mode, in_format, in_X0, in_Y0,
    output step_X_np1, step_Y_np1, out_ready,
    input  in_ready, step_en, step_n, step_mode, step_format,
    input  step_X_n, step_Y_n, out_valid, out_X, out_Y, busy
  );
endinterface

// File: rtl/bkm_iter_ctrl.sv
// BKM iteration sequencer. It latches one operand pair and runs it through a
// single bkm_data_step instance for N_ITER cycles. It owns the X/Y state and
// the iteration index, and it returns the final X/Y over a valid/ready channel.
// Every output comes straight from a register, so the step datapath and the
// consumer see glitch-free controls.
module bkm_iter_ctrl #(
  parameter int W      = 64,
  parameter int NW     = 6,
  parameter int N_ITER = 64
) (
  input  logic            clk,
  input  logic            srst,
  bkm_iter_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Index of the last iteration. The index is compared before it is
  // incremented, so N_ITER = 2**NW does not need an extra index bit.
  localparam logic [NW-1:0] N_LAST = NW'(N_ITER - 1);

  state_t        state_r;
  logic [NW-1:0] n_r;
  logic [W-1:0]  x_r;
  logic [W-1:0]  y_r;
  logic          mode_r;
  logic [1:0]    format_r;
  logic          in_ready_r;
  logic          step_en_r;
  logic          out_valid_r;
  logic          busy_r;
  logic          accept_s;

  // Abort in IDLE suppresses the accept but does not drop in_ready.
  assign accept_s = bus.in_valid & in_ready_r & ~bus.abort;

  // Sequencer: state, iteration index, X/Y state and registered status flags.
  always_ff @(posedge clk) begin
    if (srst) begin
      state_r     <= ST_IDLE;
      n_r         <= {NW{1'b0}};
      x_r         <= {W{1'b0}};
      y_r         <= {W{1'b0}};
      mode_r      <= 1'b0;
      format_r    <= 2'b00;
      in_ready_r  <= 1'b1;
      step_en_r   <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            state_r    <= ST_ITER;
            n_r        <= {NW{1'b0}};
            x_r        <= bus.in_X0;
            y_r        <= bus.in_Y0;
            mode_r     <= bus.in_mode;
            format_r   <= bus.in_format;
            in_ready_r <= 1'b0;
            step_en_r  <= 1'b1;
            busy_r     <= 1'b1;
          end
        end
        ST_ITER: begin
          if (bus.abort) begin
            state_r    <= ST_IDLE;
            n_r        <= {NW{1'b0}};
            in_ready_r <= 1'b1;
            step_en_r  <= 1'b0;
            busy_r     <= 1'b0;
          end else begin
            x_r <= bus.step_X_np1;
            y_r <= bus.step_Y_np1;
            if (n_r == N_LAST) begin
              // n stays at the last index while the result is presented
              state_r     <= ST_DONE;
              step_en_r   <= 1'b0;
              out_valid_r <= 1'b1;
            end else begin
              n_r <= n_r + {{(NW-1){1'b0}}, 1'b1};
            end
          end
        end
        ST_DONE: begin
          // The result is dropped on abort, and in_ready only rises in the
          // cycle after the result handshake.
          if (bus.abort || bus.out_ready) begin
            state_r     <= ST_IDLE;
            n_r         <= {NW{1'b0}};
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          n_r         <= {NW{1'b0}};
          in_ready_r  <= 1'b1;
          step_en_r   <= 1'b0;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready    = in_ready_r;
  assign bus.step_en     = step_en_r;
  assign bus.step_n      = n_r;
  assign bus.step_mode   = mode_r;
  assign bus.step_format = format_r;
  assign bus.step_X_n    = x_r;
  assign bus.step_Y_n    = y_r;
  assign bus.out_valid   = out_valid_r;
  assign bus.out_X       = x_r;
  assign bus.out_Y       = y_r;
  assign bus.busy        = busy_r;

endmodule

// File: tb/tb_bkm_iter_ctrl.sv
// Directed bench for bkm_iter_ctrl. It uses the step model X+1 / Y+2.
// The main instance runs with N_ITER=4 and a second instance with N_ITER=1.
module tb_bkm_iter_ctrl;

  logic clk = 1'b0;
  logic srst;
  int   n_checks = 0;
  int   n_fail   = 0;

  bkm_iter_ctrl_if #(.W(64), .NW(6)) bus  ();
  bkm_iter_ctrl_if #(.W(64), .NW(6)) bus1 ();

  bkm_iter_ctrl #(.W(64), .NW(6), .N_ITER(4)) dut  (.clk(clk), .srst(srst), .bus(bus));
  bkm_iter_ctrl #(.W(64), .NW(6), .N_ITER(1)) dut1 (.clk(clk), .srst(srst), .bus(bus1));

  // step datapath model
  assign bus.step_X_np1  = bus.step_X_n  + 64'd1;
  assign bus.step_Y_np1  = bus.step_Y_n  + 64'd2;
  assign bus1.step_X_np1 = bus1.step_X_n + 64'd1;
  assign bus1.step_Y_np1 = bus1.step_Y_n + 64'd2;

  // clock
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    srst = 1'b1;
    tick;
    tick;
    srst = 1'b0;
    n_checks++; if (bus.in_ready !== 1'b1) begin $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); n_fail++; end
    n_checks++; if (bus.step_en !== 1'b0) begin $display("FAIL reset_step_en: got %b want 0", bus.step_en); n_fail++; end
    n_checks++; if (bus.out_valid !== 1'b0) begin $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); n_fail++; end
    n_checks++; if (bus.busy !== 1'b0) begin $display("FAIL reset_busy: got %b want 0", bus.busy); n_fail++; end
    n_checks++; if (bus.step_n !== 6'd0) begin $display("FAIL reset_step_n: got %0d want 0", bus.step_n); n_fail++; end
    n_checks++; if (bus.out_X !== 64'd0 || bus.out_Y !== 64'd0) begin $display("FAIL reset_out_xy: got %0d/%0d want 0/0", bus.out_X, bus.out_Y); n_fail++; end
    n_checks++; if (bus1.in_ready !== 1'b1 || bus1.busy !== 1'b0) begin $display("FAIL reset_dut1: got rdy=%b busy=%b want 1/0", bus1.in_ready, bus1.busy); n_fail++; end
    tick;
    n_checks++; if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin $display("FAIL reset_idle_hold: got busy=%b rdy=%b want 0/1", bus.busy, bus.in_ready); n_fail++; end
  endtask

  task automatic test_basic;
    bus.in_X0 = 64'd10; bus.in_Y0 = 64'd20; bus.in_mode = 1'b1; bus.in_format = 2'd2;
    bus.out_ready = 1'b1; bus.in_valid = 1'b1;
    tick;
    // inputs outside the accept cycle must be ignored
    bus.in_valid = 1'b0; bus.in_mode = 1'b0; bus.in_format = 2'd0; bus.in_X0 = 64'd999;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (bus.step_en !== 1'b1) begin $display("FAIL basic_step_en[%0d]: got %b want 1", i, bus.step_en); n_fail++; end
      n_checks++; if (bus.step_n !== 6'(i)) begin $display("FAIL basic_step_n[%0d]: got %0d want %0d", i, bus.step_n, i); n_fail++; end
      n_checks++; if (bus.step_X_n !== 64'(10 + i) || bus.step_Y_n !== 64'(20 + 2 * i)) begin $display("FAIL basic_step_xy[%0d]: got %0d/%0d want %0d/%0d", i, bus.step_X_n, bus.step_Y_n, 10 + i, 20 + 2 * i); n_fail++; end
      n_checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin $display("FAIL basic_iter_flags[%0d]: got ov=%b rdy=%b want 0/0", i, bus.out_valid, bus.in_ready); n_fail++; end
      n_checks++; if (bus.step_mode !== 1'b1 || bus.step_format !== 2'd2) begin $display("FAIL basic_latched[%0d]: got mode=%b fmt=%0d want 1/2", i, bus.step_mode, bus.step_format); n_fail++; end
      tick;
    end
    n_checks++; if (bus.out_valid !== 1'b1 || bus.step_en !== 1'b0) begin $display("FAIL basic_done_flags: got ov=%b en=%b want 1/0", bus.out_valid, bus.step_en); n_fail++; end
    n_checks++; if (bus.out_X !== 64'd14 || bus.out_Y !== 64'd28) begin $display("FAIL basic_result: got %0d/%0d want 14/28", bus.out_X, bus.out_Y); n_fail++; end
    n_checks++; if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin $display("FAIL basic_done_rdy: got rdy=%b busy=%b want 0/1", bus.in_ready, bus.busy); n_fail++; end
    tick;
    n_checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin $display("FAIL basic_release: got ov=%b rdy=%b busy=%b want 0/1/0", bus.out_valid, bus.in_ready, bus.busy); n_fail++; end
  endtask

  task automatic test_backpressure;
    bus.out_ready = 1'b0; bus.in_X0 = 64'd10; bus.in_Y0 = 64'd20; bus.in_valid = 1'b1;
    tick;
    bus.in_valid = 1'b0;
    repeat (4) tick;
    // a pending request during DONE must not be taken
    bus.in_valid = 1'b1; bus.in_X0 = 64'd55;
    for (int i = 0; i < 7; i++) begin
      n_checks++; if (bus.out_valid !== 1'b1 || bus.out_X !== 64'd14) begin $display("FAIL bp_hold[%0d]: got ov=%b X=%0d want 1/14", i, bus.out_valid, bus.out_X); n_fail++; end
      n_checks++; if (bus.in_ready !== 1'b0) begin $display("FAIL bp_in_ready[%0d]: got %b want 0", i, bus.in_ready); n_fail++; end
      tick;
    end
    bus.out_ready = 1'b1; bus.in_valid = 1'b0;
    n_checks++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin $display("FAIL bp_hs_cycle: got ov=%b rdy=%b want 1/0", bus.out_valid, bus.in_ready); n_fail++; end
    tick;
    n_checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin $display("FAIL bp_release: got rdy=%b ov=%b busy=%b want 1/0/0", bus.in_ready, bus.out_valid, bus.busy); n_fail++; end
    tick;
    n_checks++; if (bus.busy !== 1'b0) begin $display("FAIL bp_no_stale_accept: got busy=%b want 0", bus.busy); n_fail++; end
  endtask

  task automatic test_back_to_back;
    bus.out_ready = 1'b1; bus.in_X0 = 64'd10; bus.in_Y0 = 64'd20; bus.in_valid = 1'b1;
    tick;
    bus.in_X0 = 64'd100; bus.in_Y0 = 64'd200;
    repeat (4) tick;
    n_checks++; if (bus.out_valid !== 1'b1 || bus.out_X !== 64'd14) begin $display("FAIL b2b_first: got ov=%b X=%0d want 1/14", bus.out_valid, bus.out_X); n_fail++; end
    tick;
    n_checks++; if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin $display("FAIL b2b_gap: got rdy=%b busy=%b want 1/0", bus.in_ready, bus.busy); n_fail++; end
    tick;
    bus.in_valid = 1'b0;
    n_checks++; if (bus.busy !== 1'b1 || bus.step_X_n !== 64'd100 || bus.step_n !== 6'd0) begin $display("FAIL b2b_second_accept: got busy=%b X=%0d n=%0d want 1/100/0", bus.busy, bus.step_X_n, bus.step_n); n_fail++; end
    repeat (4) tick;
    n_checks++; if (bus.out_valid !== 1'b1 || bus.out_X !== 64'd104 || bus.out_Y !== 64'd208) begin $display("FAIL b2b_second_result: got ov=%b %0d/%0d want 1/104/208", bus.out_valid, bus.out_X, bus.out_Y); n_fail++; end
    tick;
  endtask

  task automatic test_abort;
    bus.out_ready = 1'b1; bus.in_X0 = 64'd50; bus.in_Y0 = 64'd50; bus.in_valid = 1'b1;
    tick;
    bus.in_valid = 1'b0;
    tick;
    n_checks++; if (bus.step_n !== 6'd1 || bus.step_en !== 1'b1) begin $display("FAIL abort_pre: got n=%0d en=%b want 1/1", bus.step_n, bus.step_en); n_fail++; end
    bus.abort = 1'b1;
    tick;
    bus.abort = 1'b0;
    n_checks++; if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.step_en !== 1'b0) begin $display("FAIL abort_iter_idle: got rdy=%b busy=%b en=%b want 1/0/0", bus.in_ready, bus.busy, bus.step_en); n_fail++; end
    n_checks++; if (bus.step_n !== 6'd0) begin $display("FAIL abort_n_clear: got %0d want 0", bus.step_n); n_fail++; end
    for (int i = 0; i < 6; i++) begin
      n_checks++; if (bus.out_valid !== 1'b0) begin $display("FAIL abort_no_valid[%0d]: got %b want 0", i, bus.out_valid); n_fail++; end
      tick;
    end
    // abort while idle blocks that cycle's accept
    bus.in_X0 = 64'd0; bus.in_Y0 = 64'd0; bus.in_valid = 1'b1; bus.abort = 1'b1;
    tick;
    bus.abort = 1'b0;
    n_checks++; if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin $display("FAIL abort_idle_block: got busy=%b rdy=%b want 0/1", bus.busy, bus.in_ready); n_fail++; end
    tick;
    bus.in_valid = 1'b0;
    n_checks++; if (bus.busy !== 1'b1 || bus.step_X_n !== 64'd0) begin $display("FAIL abort_reaccept: got busy=%b X=%0d want 1/0", bus.busy, bus.step_X_n); n_fail++; end
    repeat (4) tick;
    n_checks++; if (bus.out_valid !== 1'b1 || bus.out_X !== 64'd4 || bus.out_Y !== 64'd8) begin $display("FAIL abort_follow_result: got ov=%b %0d/%0d want 1/4/8", bus.out_valid, bus.out_X, bus.out_Y); n_fail++; end
    tick;
    // abort while the result is waiting in DONE
    bus.out_ready = 1'b0; bus.in_X0 = 64'd10; bus.in_valid = 1'b1;
    tick;
    bus.in_valid = 1'b0;
    repeat (4) tick;
    n_checks++; if (bus.out_valid !== 1'b1) begin $display("FAIL abort_done_pre: got %b want 1", bus.out_valid); n_fail++; end
    bus.abort = 1'b1;
    tick;
    bus.abort = 1'b0;
    n_checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin $display("FAIL abort_done_idle: got ov=%b rdy=%b busy=%b want 0/1/0", bus.out_valid, bus.in_ready, bus.busy); n_fail++; end
    bus.out_ready = 1'b1;
  endtask

  task automatic test_srst;
    bus.in_X0 = 64'd10; bus.in_Y0 = 64'd20; bus.in_mode = 1'b1; bus.in_format = 2'd3; bus.in_valid = 1'b1;
    tick;
    bus.in_valid = 1'b0;
    tick;
    srst = 1'b1;
    tick;
    srst = 1'b0;
    n_checks++; if (bus.in_ready !== 1'b1 || bus.step_en !== 1'b0 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin $display("FAIL srst_iter_flags: got rdy=%b en=%b ov=%b busy=%b want 1/0/0/0", bus.in_ready, bus.step_en, bus.out_valid, bus.busy); n_fail++; end
    n_checks++; if (bus.step_n !== 6'd0 || bus.out_X !== 64'd0 || bus.out_Y !== 64'd0) begin $display("FAIL srst_iter_data: got n=%0d %0d/%0d want 0/0/0", bus.step_n, bus.out_X, bus.out_Y); n_fail++; end
    n_checks++; if (bus.step_mode !== 1'b0 || bus.step_format !== 2'd0) begin $display("FAIL srst_iter_cfg: got mode=%b fmt=%0d want 0/0", bus.step_mode, bus.step_format); n_fail++; end
    bus.out_ready = 1'b0; bus.in_valid = 1'b1;
    tick;
    bus.in_valid = 1'b0;
    repeat (4) tick;
    n_checks++; if (bus.out_valid !== 1'b1 || bus.out_X !== 64'd14) begin $display("FAIL srst_done_pre: got ov=%b X=%0d want 1/14", bus.out_valid, bus.out_X); n_fail++; end
    // srst wins over abort and over every handshake
    srst = 1'b1; bus.abort = 1'b1; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    tick;
    srst = 1'b0; bus.abort = 1'b0; bus.in_valid = 1'b0;
    n_checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.step_en !== 1'b0) begin $display("FAIL srst_done_flags: got rdy=%b ov=%b busy=%b en=%b want 1/0/0/0", bus.in_ready, bus.out_valid, bus.busy, bus.step_en); n_fail++; end
    n_checks++; if (bus.out_X !== 64'd0 || bus.out_Y !== 64'd0 || bus.step_n !== 6'd0) begin $display("FAIL srst_done_data: got %0d/%0d n=%0d want 0/0/0", bus.out_X, bus.out_Y, bus.step_n); n_fail++; end
    tick;
    n_checks++; if (bus.busy !== 1'b0) begin $display("FAIL srst_after: got busy=%b want 0", bus.busy); n_fail++; end
  endtask

  task automatic test_n_iter1;
    bus1.in_X0 = 64'd7; bus1.in_Y0 = 64'd3; bus1.out_ready = 1'b1; bus1.in_valid = 1'b1;
    tick;
    bus1.in_valid = 1'b0;
    n_checks++; if (bus1.step_en !== 1'b1 || bus1.step_n !== 6'd0 || bus1.out_valid !== 1'b0) begin $display("FAIL n1_iter: got en=%b n=%0d ov=%b want 1/0/0", bus1.step_en, bus1.step_n, bus1.out_valid); n_fail++; end
    tick;
    n_checks++; if (bus1.out_valid !== 1'b1 || bus1.step_en !== 1'b0 || bus1.step_n !== 6'd0) begin $display("FAIL n1_done_flags: got ov=%b en=%b n=%0d want 1/0/0", bus1.out_valid, bus1.step_en, bus1.step_n); n_fail++; end
    n_checks++; if (bus1.out_X !== 64'd8 || bus1.out_Y !== 64'd5) begin $display("FAIL n1_result: got %0d/%0d want 8/5", bus1.out_X, bus1.out_Y); n_fail++; end
    tick;
    n_checks++; if (bus1.out_valid !== 1'b0 || bus1.in_ready !== 1'b1) begin $display("FAIL n1_release: got ov=%b rdy=%b want 0/1", bus1.out_valid, bus1.in_ready); n_fail++; end
  endtask

  // test sequence
  initial begin
    srst = 1'b1;
    bus.abort = 1'b0; bus.in_valid = 1'b0; bus.in_mode = 1'b0; bus.in_format = 2'd0;
    bus.in_X0 = 64'd0; bus.in_Y0 = 64'd0; bus.out_ready = 1'b0;
    bus1.abort = 1'b0; bus1.in_valid = 1'b0; bus1.in_mode = 1'b0; bus1.in_format = 2'd0;
    bus1.in_X0 = 64'd0; bus1.in_Y0 = 64'd0; bus1.out_ready = 1'b0;
    test_reset;
    test_basic;
    test_backpressure;
    test_back_to_back;
    test_abort;
    test_srst;
    test_n_iter1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
